// File: rtl/i2c_target_model.sv
// rtl/i2c_target_model.sv - open-drain I2C bus resolver with a register-memory target
//
// Purpose: wired-AND resolution of SCL/SDA over NumDrivers open-drain drivers plus this
//   target's own SDA pull-down, and an I2C target at TargetAddr backed by MemDepth bytes.
// Ports:
//   clk_i, rst_ni          oversampling clock (>=8x SCL), asynchronous active-low reset
//   scl_o_i, scl_oe_i      per-driver SCL value / output enable
//   sda_o_i, sda_oe_i      per-driver SDA value / output enable
//   scl_o, sda_o           resolved bus levels (sda_o includes the target pull-down)
//   busy_o                 high from START to STOP
//   selected_o             high while this target is addressed
//   wr_pulse_o             one-cycle strobe per data byte committed to memory
module i2c_target_model #(
    parameter int         NumDrivers = 2,
    parameter logic [6:0] TargetAddr = 7'h50,
    parameter int         MemDepth   = 256,
    parameter logic [7:0] ResetByte  = 8'h00
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumDrivers-1:0] scl_o_i,
    input  logic [NumDrivers-1:0] scl_oe_i,
    input  logic [NumDrivers-1:0] sda_o_i,
    input  logic [NumDrivers-1:0] sda_oe_i,
    output logic                  scl_o,
    output logic                  sda_o,
    output logic                  busy_o,
    output logic                  selected_o,
    output logic                  wr_pulse_o
);

    localparam int AW = (MemDepth > 1) ? $clog2(MemDepth) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic       r_sda_pd;
    logic       r_scl_q, r_scl_p, r_sda_q, r_sda_p;
    logic       r_vld_q, r_vld_p;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_ptr;
    logic       r_ptr_set;
    logic       r_rw;
    logic       r_ack_seen;
    logic       r_nack;
    logic       r_wr_pulse;
    logic [7:0] r_mem [MemDepth];

    logic       w_scl, w_sda;
    logic       w_start, w_stop, w_rise, w_fall, w_last_bit;
    logic [7:0] w_byte, w_ptr_inc, w_rd_byte, w_rd_next;

    function automatic logic [7:0] ptr_wrap(input logic [8:0] v);
        logic [8:0] w_m;
        w_m = v % 9'(MemDepth);
        return w_m[7:0];
    endfunction

    // A driver pulls low only when enabled with a 0; enabled-with-1 counts as released.
    assign w_scl = ~|(scl_oe_i & ~scl_o_i);
    assign w_sda = ~(|(sda_oe_i & ~sda_o_i) | r_sda_pd);
    assign scl_o = w_scl;
    assign sda_o = w_sda;

    // Two-deep bus sample; edges are only trusted once both samples hold real bus values,
    // so a bus held low across reset release cannot fake a START.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scl_q <= 1'b1;
            r_scl_p <= 1'b1;
            r_sda_q <= 1'b1;
            r_sda_p <= 1'b1;
            r_vld_q <= 1'b0;
            r_vld_p <= 1'b0;
        end else begin
            r_scl_q <= w_scl;
            r_scl_p <= r_scl_q;
            r_sda_q <= w_sda;
            r_sda_p <= r_sda_q;
            r_vld_q <= 1'b1;
            r_vld_p <= r_vld_q;
        end
    end

    // START/STOP need only SCL high in the current sample, so a START coinciding with an
    // SCL rise is still seen as START and takes priority over the bit.
    assign w_start    = r_vld_p & r_scl_q & r_sda_p & ~r_sda_q;
    assign w_stop     = r_vld_p & r_scl_q & ~r_sda_p & r_sda_q;
    assign w_rise     = r_vld_p & r_scl_q & ~r_scl_p;
    assign w_fall     = r_vld_p & ~r_scl_q & r_scl_p;
    assign w_last_bit = (r_bit_cnt == 4'd7);
    assign w_byte     = {r_shift[6:0], r_sda_q};
    assign w_ptr_inc  = ptr_wrap({1'b0, r_ptr} + 9'd1);
    assign w_rd_byte  = r_mem[r_ptr[AW-1:0]];
    assign w_rd_next  = r_mem[w_ptr_inc[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_start) begin
            w_next_state = S_ADDR;
        end else if (w_stop) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR:
                    if (w_rise && w_last_bit)
                        w_next_state = (w_byte[7:1] == TargetAddr) ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:
                    if (w_fall && r_ack_seen)
                        w_next_state = r_rw ? S_READ : (r_ptr_set ? S_WRITE : S_PTR);
                S_PTR:
                    if (w_rise && w_last_bit) w_next_state = S_PTR_ACK;
                S_PTR_ACK, S_WRITE_ACK:
                    if (w_fall && r_ack_seen) w_next_state = S_WRITE;
                S_WRITE:
                    if (w_rise && w_last_bit) w_next_state = S_WRITE_ACK;
                S_READ:
                    if (w_rise && w_last_bit) w_next_state = S_READ_ACK;
                S_READ_ACK:
                    if (w_fall && r_ack_seen) w_next_state = r_nack ? S_IGNORE : S_READ;
                default: ;
            endcase
        end
    end

    // Datapath. Each ACK state sees fall (start driving ACK), rise (ACK bit), fall (leave);
    // r_ack_seen tells the two falls apart. SDA drive only changes on a detected fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sda_pd   <= 1'b0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_ptr      <= 8'h00;
            r_ptr_set  <= 1'b0;
            r_rw       <= 1'b0;
            r_ack_seen <= 1'b0;
            r_nack     <= 1'b0;
            r_wr_pulse <= 1'b0;
            for (int i = 0; i < MemDepth; i++) r_mem[i] <= ResetByte;
        end else begin
            r_wr_pulse <= 1'b0;
            if (w_start) begin
                r_bit_cnt <= 4'd0;
                r_ptr_set <= 1'b0;
                r_sda_pd  <= 1'b0;
            end else if (w_stop) begin
                r_sda_pd  <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WRITE: begin
                        if (w_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_last_bit) begin
                                r_ack_seen <= 1'b0;
                                if (r_state == S_ADDR) r_rw <= w_byte[0];
                                if (r_state == S_PTR) begin
                                    r_ptr     <= ptr_wrap({1'b0, w_byte});
                                    r_ptr_set <= 1'b1;
                                end
                                if (r_state == S_WRITE) begin
                                    r_mem[r_ptr[AW-1:0]] <= w_byte;
                                    r_wr_pulse           <= 1'b1;
                                    r_ptr                <= w_ptr_inc;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WRITE_ACK: begin
                        if (w_rise) begin
                            r_ack_seen <= 1'b1;
                        end else if (w_fall) begin
                            if (!r_ack_seen) begin
                                r_sda_pd <= 1'b1;
                            end else begin
                                r_bit_cnt <= 4'd0;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    r_sda_pd <= ~w_rd_byte[7];
                                    r_shift  <= {w_rd_byte[6:0], 1'b0};
                                end else begin
                                    r_sda_pd <= 1'b0;
                                end
                            end
                        end
                    end
                    S_READ: begin
                        if (w_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_last_bit) r_ack_seen <= 1'b0;
                        end else if (w_fall) begin
                            r_sda_pd <= ~r_shift[7];
                            r_shift  <= {r_shift[6:0], 1'b0};
                        end
                    end
                    S_READ_ACK: begin
                        if (w_rise) begin
                            r_ack_seen <= 1'b1;
                            r_nack     <= r_sda_q;
                        end else if (w_fall) begin
                            if (!r_ack_seen || r_nack) begin
                                r_sda_pd <= 1'b0;
                            end else begin
                                r_ptr     <= w_ptr_inc;
                                r_bit_cnt <= 4'd0;
                                r_sda_pd  <= ~w_rd_next[7];
                                r_shift   <= {w_rd_next[6:0], 1'b0};
                            end
                        end
                    end
                    default: r_sda_pd <= 1'b0;
                endcase
            end
        end
    end

    assign busy_o     = (r_state != S_IDLE);
    assign selected_o = (r_state != S_IDLE) && (r_state != S_ADDR) && (r_state != S_IGNORE);
    assign wr_pulse_o = r_wr_pulse;

endmodule
